// File: rtl/ex_stage_muldiv.sv
// Execute stage: MEM/WB operand forwarding, single-cycle ALU, iterative
// radix-2 multiply/divide with HI/LO registers, stall/flush handling and a
// registered EX/MEM output.
module ex_stage_muldiv #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5,
   parameter int SH_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [4:0]        in_op,
   input  logic [REG_AW-1:0] in_rs_addr,
   input  logic [REG_AW-1:0] in_rt_addr,
   input  logic [XLEN-1:0]   in_rs_data,
   input  logic [XLEN-1:0]   in_rt_data,
   input  logic [XLEN-1:0]   in_imm,
   input  logic              in_use_imm,
   input  logic [SH_W-1:0]   in_shamt,
   input  logic [REG_AW-1:0] in_wr_addr,
   input  logic              in_reg_write,
   input  logic              in_mem_write,
   input  logic [1:0]        in_mem_to_reg,
   input  logic              mem_reg_write,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] mem_wr_addr,
   input  logic [REG_AW-1:0] wb_wr_addr,
   input  logic [XLEN-1:0]   mem_wr_data,
   input  logic [XLEN-1:0]   wb_wr_data,
   input  logic              flush,
   output logic              stall_out,
   output logic              out_valid,
   output logic [XLEN-1:0]   out_result,
   output logic [XLEN-1:0]   out_store_data,
   output logic [REG_AW-1:0] out_wr_addr,
   output logic              out_reg_write,
   output logic              out_mem_write,
   output logic [1:0]        out_mem_to_reg,
   output logic [XLEN-1:0]   hi,
   output logic [XLEN-1:0]   lo
);

   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_XOR   = 5'd4;
   localparam logic [4:0] OP_NOR   = 5'd5;
   localparam logic [4:0] OP_SLT   = 5'd6;
   localparam logic [4:0] OP_SLTU  = 5'd7;
   localparam logic [4:0] OP_SLL   = 5'd8;
   localparam logic [4:0] OP_SRL   = 5'd9;
   localparam logic [4:0] OP_SRA   = 5'd10;
   localparam logic [4:0] OP_MULT  = 5'd11;
   localparam logic [4:0] OP_MULTU = 5'd12;
   localparam logic [4:0] OP_DIV   = 5'd13;
   localparam logic [4:0] OP_DIVU  = 5'd14;
   localparam logic [4:0] OP_MFHI  = 5'd15;
   localparam logic [4:0] OP_MFLO  = 5'd16;
   localparam logic [4:0] OP_LUI   = 5'd17;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t state_reg, state_next;

   // ------------------------------------------------------------------
   // Operand forwarding: index 0 = rs, index 1 = rt. MEM beats WB, and
   // register 0 never forwards.
   // ------------------------------------------------------------------
   logic [1:0][REG_AW-1:0] src_addr;
   logic [1:0][XLEN-1:0]   rf_data;
   logic [1:0][XLEN-1:0]   fwd_data;

   assign src_addr[0] = in_rs_addr;
   assign src_addr[1] = in_rt_addr;
   assign rf_data[0]  = in_rs_data;
   assign rf_data[1]  = in_rt_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         logic mem_hit, wb_hit;
         assign mem_hit = mem_reg_write && (mem_wr_addr != '0) && (mem_wr_addr == src_addr[gi]);
         assign wb_hit  = wb_reg_write  && (wb_wr_addr  != '0) && (wb_wr_addr  == src_addr[gi]);
         assign fwd_data[gi] = mem_hit ? mem_wr_data :
                               wb_hit  ? wb_wr_data  : rf_data[gi];
      end
   endgenerate

   logic [XLEN-1:0] op_a, rt_fwd, op_b;
   assign op_a   = fwd_data[0];
   assign rt_fwd = fwd_data[1];
   assign op_b   = in_use_imm ? in_imm : rt_fwd;

   // ------------------------------------------------------------------
   // Op decode for the multi-cycle unit
   // ------------------------------------------------------------------
   logic is_md, is_signed_md, is_div_op;
   assign is_md        = (in_op == OP_MULT) || (in_op == OP_MULTU) ||
                         (in_op == OP_DIV)  || (in_op == OP_DIVU);
   assign is_signed_md = (in_op == OP_MULT) || (in_op == OP_DIV);
   assign is_div_op    = (in_op == OP_DIV)  || (in_op == OP_DIVU);

   logic            neg_a, neg_b;
   logic [XLEN-1:0] abs_a, abs_b;
   assign neg_a = is_signed_md && op_a[XLEN-1];
   assign neg_b = is_signed_md && op_b[XLEN-1];
   assign abs_a = neg_a ? (~op_a + 1'b1) : op_a;
   assign abs_b = neg_b ? (~op_b + 1'b1) : op_b;

   logic [XLEN-1:0] hi_reg, lo_reg;

   // Single-cycle ALU; muldiv and undefined codes produce 0
   logic [XLEN-1:0] alu_res;
   always_comb begin
      alu_res = '0;
      case (in_op)
         OP_ADD:  alu_res = op_a + op_b;
         OP_SUB:  alu_res = op_a - op_b;
         OP_AND:  alu_res = op_a & op_b;
         OP_OR:   alu_res = op_a | op_b;
         OP_XOR:  alu_res = op_a ^ op_b;
         OP_NOR:  alu_res = ~(op_a | op_b);
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         OP_SLL:  alu_res = op_b << in_shamt;
         OP_SRL:  alu_res = op_b >> in_shamt;
         OP_SRA:  alu_res = XLEN'($signed(op_b) >>> in_shamt);
         OP_MFHI: alu_res = hi_reg;
         OP_MFLO: alu_res = lo_reg;
         OP_LUI:  alu_res = op_b << (XLEN/2);
         default: alu_res = '0;
      endcase
   end

   // ------------------------------------------------------------------
   // Iterative datapath. acc_reg/quo_reg form the {upper,lower} pair of
   // the product, or remainder/quotient while dividing. opd_reg holds the
   // multiplicand or the divisor magnitude.
   // ------------------------------------------------------------------
   logic [XLEN-1:0] acc_reg, quo_reg, opd_reg;
   logic [SH_W-1:0] cnt_reg;
   logic            neg_a_reg, neg_b_reg, is_div_reg;

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] div_sub;
   logic [XLEN-1:0] acc_next, quo_next;

   // One radix-2 step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_sum   = {1'b0, acc_reg} + (quo_reg[0] ? {1'b0, opd_reg} : '0);
      div_shift = {acc_reg, quo_reg[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opd_reg});
      // When div_ge holds the true difference is below the divisor, so the
      // low XLEN bits are exact.
      div_sub   = div_shift[XLEN-1:0] - opd_reg;
      if (is_div_reg) begin
         acc_next = div_ge ? div_sub : div_shift[XLEN-1:0];
         quo_next = {quo_reg[XLEN-2:0], div_ge};
      end else begin
         acc_next = mul_sum[XLEN:1];
         quo_next = {mul_sum[0], quo_reg[XLEN-1:1]};
      end
   end

   // Sign fix-up of the finished magnitude result
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   q_fix, r_fix, hi_fix, lo_fix;
   always_comb begin
      prod     = {acc_reg, quo_reg};
      prod_fix = (neg_a_reg ^ neg_b_reg) ? (~prod + 1'b1) : prod;
      q_fix    = (neg_a_reg ^ neg_b_reg) ? (~quo_reg + 1'b1) : quo_reg;
      // Remainder follows the dividend. With a zero divisor every step
      // shifts the dividend straight into acc_reg, so r_fix is the dividend.
      r_fix    = neg_a_reg ? (~acc_reg + 1'b1) : acc_reg;
      if (is_div_reg) begin
         hi_fix = r_fix;
         lo_fix = (opd_reg == '0) ? '1 : q_fix;
      end else begin
         hi_fix = prod_fix[2*XLEN-1:XLEN];
         lo_fix = prod_fix[XLEN-1:0];
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   logic start;
   assign start = (state_reg == S_IDLE) && in_valid && is_md && !flush;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; flush aborts a running operation
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (start) state_next = S_RUN;
         S_RUN: begin
            if (flush)                state_next = S_IDLE;
            else if (cnt_reg == '0)   state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // The stall is released in DONE so the next instruction enters on the
   // retire edge; reset forces it low at once.
   assign stall_out = rst_n && (start || ((state_reg == S_RUN) && !flush));

   // Operand capture and per-step update of the iterative datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg    <= '0;
         quo_reg    <= '0;
         opd_reg    <= '0;
         cnt_reg    <= '0;
         neg_a_reg  <= 1'b0;
         neg_b_reg  <= 1'b0;
         is_div_reg <= 1'b0;
      end else if (start) begin
         acc_reg    <= '0;
         quo_reg    <= is_div_op ? abs_a : abs_b;
         opd_reg    <= is_div_op ? abs_b : abs_a;
         cnt_reg    <= SH_W'(XLEN-1);
         neg_a_reg  <= neg_a;
         neg_b_reg  <= neg_b;
         is_div_reg <= is_div_op;
      end else if (state_reg == S_RUN && !flush) begin
         acc_reg <= acc_next;
         quo_reg <= quo_next;
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   // HI/LO commit on the retire edge unless flushed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_reg <= '0;
         lo_reg <= '0;
      end else if (state_reg == S_DONE && !flush) begin
         hi_reg <= hi_fix;
         lo_reg <= lo_fix;
      end
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

   // ------------------------------------------------------------------
   // EX/MEM register
   // ------------------------------------------------------------------
   logic              out_valid_reg, out_valid_next;
   logic [XLEN-1:0]   out_result_reg, out_result_next;
   logic [XLEN-1:0]   out_store_reg, out_store_next;
   logic [REG_AW-1:0] out_wr_addr_reg, out_wr_addr_next;
   logic              out_reg_write_reg, out_reg_write_next;
   logic              out_mem_write_reg, out_mem_write_next;
   logic [1:0]        out_mem_to_reg_reg, out_mem_to_reg_next;

   // EX/MEM contents: ALU retire in IDLE, muldiv retire in DONE, else bubble
   always_comb begin
      out_valid_next      = 1'b0;
      out_result_next     = alu_res;
      out_store_next      = rt_fwd;
      out_wr_addr_next    = in_wr_addr;
      out_reg_write_next  = 1'b0;
      out_mem_write_next  = 1'b0;
      out_mem_to_reg_next = in_mem_to_reg;
      case (state_reg)
         S_IDLE: begin
            if (in_valid && !flush && !is_md) begin
               out_valid_next     = 1'b1;
               out_reg_write_next = in_reg_write;
               out_mem_write_next = in_mem_write;
            end
         end
         S_DONE: begin
            if (!flush) begin
               out_valid_next  = 1'b1;
               out_result_next = lo_fix;
            end
         end
         default: ;
      endcase
   end

   // EX/MEM register update every cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg      <= 1'b0;
         out_result_reg     <= '0;
         out_store_reg      <= '0;
         out_wr_addr_reg    <= '0;
         out_reg_write_reg  <= 1'b0;
         out_mem_write_reg  <= 1'b0;
         out_mem_to_reg_reg <= '0;
      end else begin
         out_valid_reg      <= out_valid_next;
         out_result_reg     <= out_result_next;
         out_store_reg      <= out_store_next;
         out_wr_addr_reg    <= out_wr_addr_next;
         out_reg_write_reg  <= out_reg_write_next;
         out_mem_write_reg  <= out_mem_write_next;
         out_mem_to_reg_reg <= out_mem_to_reg_next;
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_result     = out_result_reg;
   assign out_store_data = out_store_reg;
   assign out_wr_addr    = out_wr_addr_reg;
   assign out_reg_write  = out_reg_write_reg;
   assign out_mem_write  = out_mem_write_reg;
   assign out_mem_to_reg = out_mem_to_reg_reg;

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv (XLEN=32).
module tb_ex_stage_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [4:0]  in_op;
   logic [4:0]  in_rs_addr, in_rt_addr;
   logic [31:0] in_rs_data, in_rt_data, in_imm;
   logic        in_use_imm;
   logic [4:0]  in_shamt;
   logic [4:0]  in_wr_addr;
   logic        in_reg_write, in_mem_write;
   logic [1:0]  in_mem_to_reg;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_wr_addr, wb_wr_addr;
   logic [31:0] mem_wr_data, wb_wr_data;
   logic        flush;
   logic        stall_out, out_valid;
   logic [31:0] out_result, out_store_data;
   logic [4:0]  out_wr_addr;
   logic        out_reg_write, out_mem_write;
   logic [1:0]  out_mem_to_reg;
   logic [31:0] hi, lo;

   int n_tests = 0;
   int n_fail  = 0;

   ex_stage_muldiv #(.XLEN(32), .REG_AW(5), .SH_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_op(in_op),
      .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
      .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_shamt(in_shamt), .in_wr_addr(in_wr_addr),
      .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
      .in_mem_to_reg(in_mem_to_reg), .mem_reg_write(mem_reg_write),
      .wb_reg_write(wb_reg_write), .mem_wr_addr(mem_wr_addr),
      .wb_wr_addr(wb_wr_addr), .mem_wr_data(mem_wr_data),
      .wb_wr_data(wb_wr_data), .flush(flush), .stall_out(stall_out),
      .out_valid(out_valid), .out_result(out_result),
      .out_store_data(out_store_data), .out_wr_addr(out_wr_addr),
      .out_reg_write(out_reg_write), .out_mem_write(out_mem_write),
      .out_mem_to_reg(out_mem_to_reg), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction at the falling edge, no forwarding by default
   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic ui, input logic [4:0] sh);
      @(negedge clk);
      in_valid = 1'b1; in_op = op;
      in_rs_addr = 5'd1; in_rt_addr = 5'd2;
      in_rs_data = a; in_rt_data = b; in_imm = imm; in_use_imm = ui; in_shamt = sh;
      in_wr_addr = 5'd9; in_reg_write = 1'b1; in_mem_write = 1'b0; in_mem_to_reg = 2'd0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      mem_wr_addr = 5'd0; wb_wr_addr = 5'd0; mem_wr_data = '0; wb_wr_data = '0;
      flush = 1'b0;
   endtask

   task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic ui,
                      input logic [4:0] sh, input logic [31:0] exp);
      drive(op, a, b, imm, ui, sh);
      @(posedge clk); #1;
      check({tag, ".result"}, 64'(out_result), 64'(exp));
      check({tag, ".valid"},  64'(out_valid), 64'd1);
      $display("[TB] %s op=%0d a=%h b=%h -> result=%h", tag, op, a, b, out_result);
   endtask

   task automatic md(input string tag, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int cnt;
      drive(op, a, b, 32'd0, 1'b0, 5'd0);
      #1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (!stall_out) break;
         cnt++;
         @(posedge clk); #1;
      end
      check({tag, ".stall_cycles"}, 64'(cnt), 64'd33);
      @(posedge clk); #1;
      check({tag, ".valid"},     64'(out_valid), 64'd1);
      check({tag, ".reg_write"}, 64'(out_reg_write), 64'd0);
      check({tag, ".hi"},        64'(hi), 64'(exp_hi));
      check({tag, ".lo"},        64'(lo), 64'(exp_lo));
      $display("[TB] %s op=%0d a=%h b=%h stall=%0d -> hi=%h lo=%h", tag, op, a, b, cnt, hi, lo);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rs_addr = '0; in_rt_addr = '0;
      in_rs_data = '0; in_rt_data = '0; in_imm = '0; in_use_imm = 1'b0; in_shamt = '0;
      in_wr_addr = '0; in_reg_write = 1'b0; in_mem_write = 1'b0; in_mem_to_reg = '0;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0; mem_wr_addr = '0; wb_wr_addr = '0;
      mem_wr_data = '0; wb_wr_data = '0; flush = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset.valid",  64'(out_valid), 64'd0);
      check("reset.result", 64'(out_result), 64'd0);
      check("reset.stall",  64'(stall_out), 64'd0);
      check("reset.hi",     64'(hi), 64'd0);
      check("reset.lo",     64'(lo), 64'd0);
      $display("[TB] reset released");
      @(negedge clk); rst_n = 1'b1;

      // MEM hit on rs, WB hit on rt
      drive(5'd0, 32'd100, 32'd200, 32'd0, 1'b0, 5'd0);
      mem_reg_write = 1'b1; mem_wr_addr = 5'd1; mem_wr_data = 32'd5;
      wb_reg_write  = 1'b1; wb_wr_addr  = 5'd2; wb_wr_data  = 32'd7;
      @(posedge clk); #1;
      check("fwd1.result",  64'(out_result), 64'd12);
      check("fwd1.wr_addr", 64'(out_wr_addr), 64'd9);
      check("fwd1.reg_wr",  64'(out_reg_write), 64'd1);
      $display("[TB] fwd1 MEM->rs WB->rt result=%h", out_result);

      // rs matches both MEM and WB: MEM wins
      drive(5'd0, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0);
      mem_reg_write = 1'b1; mem_wr_addr = 5'd1; mem_wr_data = 32'd5;
      wb_reg_write  = 1'b1; wb_wr_addr  = 5'd1; wb_wr_data  = 32'd100;
      @(posedge clk); #1;
      check("fwd2.result", 64'(out_result), 64'd12);
      $display("[TB] fwd2 MEM beats WB result=%h", out_result);

      // Register 0 never forwards
      drive(5'd0, 32'd3, 32'd4, 32'd0, 1'b0, 5'd0);
      in_rs_addr = 5'd0; in_rt_addr = 5'd0;
      mem_reg_write = 1'b1; mem_wr_addr = 5'd0; mem_wr_data = 32'd50;
      wb_reg_write  = 1'b1; wb_wr_addr  = 5'd0; wb_wr_data  = 32'd60;
      @(posedge clk); #1;
      check("fwd3.result", 64'(out_result), 64'd7);
      $display("[TB] fwd3 r0 no forward result=%h", out_result);

      // Immediate operand; store data still the forwarded rt
      drive(5'd0, 32'd1, 32'd2, 32'd10, 1'b1, 5'd0);
      in_mem_write = 1'b1;
      wb_reg_write = 1'b1; wb_wr_addr = 5'd2; wb_wr_data = 32'h55;
      @(posedge clk); #1;
      check("fwd4.result", 64'(out_result), 64'd11);
      check("fwd4.store",  64'(out_store_data), 64'h55);
      check("fwd4.mem_wr", 64'(out_mem_write), 64'd1);
      $display("[TB] fwd4 imm add result=%h store=%h", out_result, out_store_data);

      alu("add_wrap", 5'd0,  32'hFFFFFFFF, 32'd1,        32'd0, 1'b0, 5'd0, 32'h0);
      alu("sub",      5'd1,  32'd5,        32'd7,        32'd0, 1'b0, 5'd0, 32'hFFFFFFFE);
      alu("and",      5'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 1'b0, 5'd0, 32'hF000F000);
      alu("or",       5'd3,  32'hF0F0F0F0, 32'h0F000000, 32'd0, 1'b0, 5'd0, 32'hFFF0F0F0);
      alu("xor",      5'd4,  32'hFFFF0000, 32'hFF00FF00, 32'd0, 1'b0, 5'd0, 32'h00FFFF00);
      alu("nor",      5'd5,  32'hFFFF0000, 32'h0000FF00, 32'd0, 1'b0, 5'd0, 32'h000000FF);
      alu("sll",      5'd8,  32'd0,        32'd1,        32'd0, 1'b0, 5'd4, 32'h10);
      alu("srl",      5'd9,  32'd0,        32'h80000000, 32'd0, 1'b0, 5'd4, 32'h08000000);
      alu("sra",      5'd10, 32'd0,        32'h80000000, 32'd0, 1'b0, 5'd4, 32'hF8000000);
      alu("lui",      5'd17, 32'd0,        32'd0,        32'h1234, 1'b1, 5'd0, 32'h12340000);
      alu("undef",    5'd20, 32'd5,        32'd6,        32'd0, 1'b0, 5'd0, 32'h0);

      // Bubble and IDLE flush
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      check("bubble.valid",  64'(out_valid), 64'd0);
      check("bubble.reg_wr", 64'(out_reg_write), 64'd0);
      $display("[TB] bubble valid=%0d", out_valid);
      drive(5'd0, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      check("idle_flush.valid", 64'(out_valid), 64'd0);
      check("idle_flush.reg_wr", 64'(out_reg_write), 64'd0);
      $display("[TB] idle flush valid=%0d", out_valid);

      md("mult",      5'd11, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
      md("div",       5'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      md("divu_zero", 5'd14, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
      md("div_min",   5'd13, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
      md("multu",     5'd12, 32'hFFFFFFFF, 32'd2,        32'd1,        32'hFFFFFFFE);

      // MFHI right after the multiply, no extra stall
      drive(5'd15, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
      #1;
      check("mfhi.stall", 64'(stall_out), 64'd0);
      @(posedge clk); #1;
      check("mfhi.result", 64'(out_result), 64'd1);
      $display("[TB] mfhi result=%h", out_result);
      alu("mflo", 5'd16, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'hFFFFFFFE);

      // Flush in RUN cycle 10 of a DIV
      drive(5'd13, 32'd100, 32'd7, 32'd0, 1'b0, 5'd0);
      repeat (10) @(posedge clk);
      @(negedge clk); flush = 1'b1;
      #1;
      check("run_flush.stall", 64'(stall_out), 64'd0);
      @(posedge clk); #1;
      check("run_flush.valid", 64'(out_valid), 64'd0);
      check("run_flush.hi",    64'(hi), 64'd1);
      check("run_flush.lo",    64'(lo), 64'hFFFFFFFE);
      $display("[TB] run flush hi=%h lo=%h", hi, lo);
      alu("post_flush_add", 5'd0, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 32'd5);

      // Reset in the middle of a multiply
      drive(5'd11, 32'd5, 32'd6, 32'd0, 1'b0, 5'd0);
      repeat (5) @(posedge clk);
      @(negedge clk); rst_n = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst.stall",  64'(stall_out), 64'd0);
      check("midrst.valid",  64'(out_valid), 64'd0);
      check("midrst.result", 64'(out_result), 64'd0);
      check("midrst.hi",     64'(hi), 64'd0);
      check("midrst.lo",     64'(lo), 64'd0);
      $display("[TB] mid-run reset hi=%h lo=%h", hi, lo);
      @(negedge clk); rst_n = 1'b1;
      alu("slt",  5'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd1);
      alu("sltu", 5'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0);

      @(negedge clk); in_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_stage_muldiv.md
Name: ex_stage_muldiv

Overview:
Parametrised execute stage for the 5-stage pipeline. It forwards operands from MEM and WB and evaluates single-cycle ALU ops. It adds an iterative multiply/divide unit with HI/LO registers, stall and flush handling, and a registered EX/MEM output with a valid bit. It sits between the ID/EX register and the MEM stage and drives the stall input of the hazard unit.

Parameters:
XLEN, 32, datapath width (power of two, ≥8)
REG_AW, 5, register-address width
SH_W, 5, shift-amount width = log2(XLEN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  ID/EX holds a real instruction
in_op  in  5  operation code (see Behaviour)
in_rs_addr / in_rt_addr  in  REG_AW  source register numbers
in_rs_data / in_rt_data  in  XLEN  register-file read data
in_imm  in  XLEN  extended immediate
in_use_imm  in  1  operand B = in_imm instead of forwarded rt
in_shamt  in  SH_W  shift amount
in_wr_addr  in  REG_AW  destination register (already resolved)
in_reg_write, in_mem_write  in  1  control to pass through
in_mem_to_reg  in  2  control to pass through
mem_reg_write, wb_reg_write  in  1  forwarding sources valid
mem_wr_addr, wb_wr_addr  in  REG_AW  forwarding destinations
mem_wr_data, wb_wr_data  in  XLEN  forwarding data
flush  in  1  kill the instruction in EX
stall_out  out  1  hold IF/ID/EX inputs stable
out_valid  out  1  EX/MEM entry valid
out_result, out_store_data  out  XLEN  ALU result; forwarded rt
out_wr_addr  out  REG_AW
out_reg_write, out_mem_write  out  1
out_mem_to_reg  out  2
hi, lo  out  XLEN  architectural HI/LO

Behaviour:
- Reset (async): all outputs 0, HI/LO 0, FSM IDLE, counter 0.
- Forwarding, per operand: MEM match (reg_write & addr≠0 & addr==src) wins over WB match; otherwise use register-file data. Store data = forwarded rt, even when in_use_imm=1.
- Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA (shift B by in_shamt), 11 MULT, 12 MULTU, 13 DIV, 14 DIVU, 15 MFHI, 16 MFLO, 17 LUI (B<<(XLEN/2)). Codes ≥18 give result 0. ADD/SUB wrap modulo 2^XLEN; no overflow trap.
- Single-cycle ops: EX/MEM is registered at each edge when state==IDLE. Latency is 1 cycle.
- FSM IDLE/RUN/DONE:
  - IDLE + in_valid + muldiv op + !flush: capture forwarded |A|, |B| and sign flags, counter=XLEN-1, go to RUN. stall_out=1 combinationally. EX/MEM gets a bubble.
  - RUN: one radix-2 shift-add/restoring-subtract step per cycle. stall_out=1 and bubbles are emitted. At counter==0 go to DONE.
  - DONE: stall_out=0. Apply sign fix-up, write HI/LO at this edge, and retire with out_valid=1 and out_reg_write forced 0. Then return to IDLE.
  - A muldiv op occupies EX for XLEN+2 cycles, including XLEN+1 stall cycles.
- MULT/MULTU: {HI,LO} = full 2·XLEN product. DIV/DIVU: LO = quotient, HI = remainder. Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend.
- Signed MIN/−1: LO = MIN, HI = 0.
- MFHI/MFLO read HI/LO registered values. The blocking FSM guarantees HI/LO are already updated, so no HI/LO forwarding is needed.
- in_valid=0 or flush in IDLE: out_valid=0 next cycle.
- When out_valid=0: out_reg_write=0 and out_mem_write=0. Other out_* fields are don't-care but deterministic.
- flush in RUN or DONE: abort, HI/LO unchanged, go to IDLE, out_valid=0, stall_out drops the same cycle. flush has priority over completion.
- Reset mid-RUN: state returns to IDLE, HI/LO return to 0.

Test Plan:
- ADD with a MEM hit on rs (mem_wr_data=5) and a WB hit on rt (wb_wr_data=7, same rs addr also in WB) → out_result=12 next cycle. A source address of 0 never forwards.
- MULT −3×7 (XLEN=32) → stall_out high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB, out_valid=1, out_reg_write=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF×2 then MFHI next instruction → out_result=1 with no extra stall.
- flush asserted in RUN cycle 10 of a DIV → stall_out drops the same cycle, HI/LO keep their old values, out_valid=0.
- rst_n low mid-RUN → all outputs and HI/LO are 0 immediately. After release, SLT 0xFFFFFFFF,1 → 1 and SLTU → 0.
